// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, immediate-format codes, multicycle CU state and
// the static per-opcode control bundle.
package rv32i;

   localparam logic [6:0] RV32I_LUI_OPCODE    = 7'b0110111;
   localparam logic [6:0] RV32I_AUIPC_OPCODE  = 7'b0010111;
   localparam logic [6:0] RV32I_JAL_OPCODE    = 7'b1101111;
   localparam logic [6:0] RV32I_JALR_OPCODE   = 7'b1100111;
   localparam logic [6:0] RV32I_BRANCH_OPCODE = 7'b1100011;
   localparam logic [6:0] RV32I_LOAD_OPCODE   = 7'b0000011;
   localparam logic [6:0] RV32I_STORE_OPCODE  = 7'b0100011;
   localparam logic [6:0] RV32I_OP_IMM_OPCODE = 7'b0010011;
   localparam logic [6:0] RV32I_OP_OPCODE     = 7'b0110011;
   localparam logic [6:0] RV32I_FENCE_OPCODE  = 7'b0001111;
   localparam logic [6:0] RV32I_SYSTEM_OPCODE = 7'b1110011;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5,
      HALT    = 3'd6,
      TRAP    = 3'd7
   } cu_state_t;

   // Opcode-only controls; the FSM decides in which state each one is visible.
   typedef struct packed {
      logic [2:0] imm;
      logic       alu_src;
      logic       load;
      logic       store;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       sys;
   } cu_ctrl_t;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode decoder: maps the 7-bit opcode to the static control bundle
// and flags opcodes outside RV32I.
module cu_opcode_decode
   import rv32i::*;
(
   input  logic [6:0] opcode,
   output cu_ctrl_t   ctrl,
   output logic       legal
);

   always_comb begin
      ctrl  = '0;
      legal = 1'b1;
      case (opcode)
         RV32I_OP_OPCODE:     ctrl.imm = IMM_I;
         RV32I_OP_IMM_OPCODE: ctrl.alu_src = 1'b1;
         RV32I_LOAD_OPCODE: begin
            ctrl.alu_src = 1'b1;
            ctrl.load    = 1'b1;
         end
         RV32I_STORE_OPCODE: begin
            ctrl.imm     = IMM_S;
            ctrl.alu_src = 1'b1;
            ctrl.store   = 1'b1;
         end
         RV32I_BRANCH_OPCODE: begin
            ctrl.imm    = IMM_B;
            ctrl.branch = 1'b1;
         end
         RV32I_LUI_OPCODE, RV32I_AUIPC_OPCODE: begin
            ctrl.imm     = IMM_U;
            ctrl.alu_src = 1'b1;
         end
         RV32I_JAL_OPCODE: begin
            ctrl.imm = IMM_J;
            ctrl.jal = 1'b1;
         end
         RV32I_JALR_OPCODE: begin
            ctrl.alu_src = 1'b1;
            ctrl.jalr    = 1'b1;
         end
         RV32I_FENCE_OPCODE, RV32I_SYSTEM_OPCODE: ctrl.sys = 1'b1;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/cu_multicycle.sv
// Multicycle RV32I control unit: IR, FETCH..WB sequencer and bounded memory waits.
// Define CU_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_inst / trap_vec_sel).
module cu_multicycle
   import rv32i::*;
#(
   parameter int INST_WIDTH     = 32,
   parameter int IMM_SEL_WIDTH  = 3,
   parameter int MEM_MODE_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [INST_WIDTH-1:0]     instruction,
   output logic                      imem_req,
   input  logic                      imem_ack,
   input  logic                      dmem_ack,
   output logic [IMM_SEL_WIDTH-1:0]  imm_type,
   output logic                      D_MEM_write,
   output logic                      D_MEM_read,
   output logic [MEM_MODE_WIDTH-1:0] D_MEM_mode,
   output logic                      RF_write,
   output logic                      RF_regDest,
   output logic                      RS2_IMM_ALU_SRC_MUX_sel,
   output logic                      DMEM_ALU_WB_MUX_sel,
   output logic                      branch,
   output logic                      jump,
   output logic                      jalr,
   output logic                      PC_write,
   output logic                      IR_write,
   output logic                      halted
`ifdef CU_ILLEGAL_TRAP_EN
   ,
   output logic                      illegal_inst,
   output logic                      trap_vec_sel
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   cu_state_t             state, state_nxt;
   logic [INST_WIDTH-1:0] ir;
   logic [CNT_W-1:0]      wait_cnt;
   cu_ctrl_t              ctrl;
   logic                  legal;
   logic                  waiting, ack, expired;
   logic                  unused_ir_bits;

   assign unused_ir_bits = ^{ir[INST_WIDTH-1:15], ir[11:7]};

   cu_opcode_decode u_decode (
      .opcode (ir[6:0]),
      .ctrl   (ctrl),
      .legal  (legal)
   );

   // An ack in the final permitted wait cycle still counts, so expiry requires !ack.
   always_comb begin
      waiting = (state == FETCH) || (state == MEM);
      ack     = (state == FETCH) ? imem_ack : dmem_ack;
      expired = waiting && !ack && (wait_cnt == CNT_LAST);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   state_nxt = FETCH;
         FETCH:  if (imem_ack) state_nxt = DECODE;
                 else if (expired) state_nxt = HALT;
`ifdef CU_ILLEGAL_TRAP_EN
         DECODE: state_nxt = legal ? EXECUTE : TRAP;
         TRAP:   state_nxt = FETCH;
`else
         DECODE: state_nxt = legal ? EXECUTE : FETCH;
         TRAP:   state_nxt = FETCH;
`endif
         EXECUTE: begin
            if (ctrl.branch || ctrl.sys)       state_nxt = FETCH;
            else if (ctrl.load || ctrl.store)  state_nxt = MEM;
            else                               state_nxt = WB;
         end
         MEM:    if (dmem_ack) state_nxt = ctrl.load ? WB : FETCH;
                 else if (expired) state_nxt = HALT;
         WB:     state_nxt = FETCH;
         HALT:   state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ir       <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && imem_ack) ir <= instruction;
         if (waiting && !ack && !expired) wait_cnt <= wait_cnt + 1'b1;
         else                             wait_cnt <= '0;
      end
   end

   // All strobes are decoded from state, so an async reset clears them immediately.
   always_comb begin
      imem_req                = 1'b0;
      imm_type                = '0;
      D_MEM_write             = 1'b0;
      D_MEM_read              = 1'b0;
      D_MEM_mode              = '0;
      RF_write                = 1'b0;
      RF_regDest              = 1'b0;
      RS2_IMM_ALU_SRC_MUX_sel = 1'b0;
      DMEM_ALU_WB_MUX_sel     = 1'b0;
      branch                  = 1'b0;
      jump                    = 1'b0;
      jalr                    = 1'b0;
      PC_write                = 1'b0;
      IR_write                = 1'b0;
      halted                  = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_inst            = 1'b0;
      trap_vec_sel            = 1'b0;
`endif
      if (state == DECODE || state == EXECUTE || state == MEM || state == WB)
         imm_type = IMM_SEL_WIDTH'(ctrl.imm);
      if (state == EXECUTE || state == MEM || state == WB)
         RS2_IMM_ALU_SRC_MUX_sel = ctrl.alu_src;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            IR_write = imem_ack;
            PC_write = imem_ack;
         end
         EXECUTE: begin
            branch   = ctrl.branch;
            jump     = ctrl.jal;
            jalr     = ctrl.jalr;
            PC_write = ctrl.jal || ctrl.jalr;
         end
         MEM: begin
            D_MEM_read  = ctrl.load;
            D_MEM_write = ctrl.store;
            D_MEM_mode  = MEM_MODE_WIDTH'(ir[14:12]);
         end
         WB: begin
            RF_write            = 1'b1;
            RF_regDest          = 1'b1;
            DMEM_ALU_WB_MUX_sel = ctrl.load;
         end
         HALT: halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
         TRAP: begin
            illegal_inst = 1'b1;
            PC_write     = 1'b1;
            trap_vec_sel = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle (TIMEOUT_CYCLES=4); trap checks follow CU_ILLEGAL_TRAP_EN.
module tb_cu_multicycle;
   import rv32i::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instruction = '0;
   logic        imem_ack = 1'b0;
   logic        dmem_ack = 1'b0;
   logic        imem_req, D_MEM_write, D_MEM_read, RF_write, RF_regDest;
   logic        RS2_IMM_ALU_SRC_MUX_sel, DMEM_ALU_WB_MUX_sel;
   logic        branch, jump, jalr, PC_write, IR_write, halted;
   logic [2:0]  imm_type, D_MEM_mode;
`ifdef CU_ILLEGAL_TRAP_EN
   logic        illegal_inst, trap_vec_sel;
`endif
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cu_multicycle #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction),
      .imem_req(imem_req), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imm_type(imm_type), .D_MEM_write(D_MEM_write), .D_MEM_read(D_MEM_read),
      .D_MEM_mode(D_MEM_mode), .RF_write(RF_write), .RF_regDest(RF_regDest),
      .RS2_IMM_ALU_SRC_MUX_sel(RS2_IMM_ALU_SRC_MUX_sel),
      .DMEM_ALU_WB_MUX_sel(DMEM_ALU_WB_MUX_sel),
      .branch(branch), .jump(jump), .jalr(jalr), .PC_write(PC_write),
      .IR_write(IR_write), .halted(halted)
`ifdef CU_ILLEGAL_TRAP_EN
      , .illegal_inst(illegal_inst), .trap_vec_sel(trap_vec_sel)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag, input cu_state_t exp);
      chk(tag, 32'(dut.state), 32'(exp));
   endtask

   // Advance to just after the next rising edge, then let combinational outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk_state("rst_state", IDLE);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_rf_write", RF_write, 0);
      chk("rst_halted", halted, 0);
      tick();
      rst_n = 1'b1;

      // ADD: spurious ack in IDLE must not load IR
      imem_ack = 1'b1; instruction = 32'h002081B3; #1;
      chk_state("add_c1_idle", IDLE);
      chk("idle_ack_ir_write", IR_write, 0);
      tick();
      chk_state("add_c2_fetch", FETCH);
      chk("add_imem_req", imem_req, 1);
      chk("add_ir_write", IR_write, 1);
      chk("add_pc_write", PC_write, 1);
      tick(); imem_ack = 1'b0; #1;
      chk_state("add_c3_decode", DECODE);
      chk("add_dec_rf_write", RF_write, 0);
      tick();
      chk_state("add_c4_execute", EXECUTE);
      chk("add_src_sel", RS2_IMM_ALU_SRC_MUX_sel, 0);
      chk("add_ex_rf_write", RF_write, 0);
      tick();
      chk_state("add_c5_wb", WB);
      chk("add_wb_rf_write", RF_write, 1);
      chk("add_wb_regdest", RF_regDest, 1);
      chk("add_wb_dmem_sel", DMEM_ALU_WB_MUX_sel, 0);
      tick();
      chk_state("add_c6_fetch", FETCH);

      // LW with three dmem wait cycles
      imem_ack = 1'b1; instruction = 32'h0000A103; #1;
      chk("lw_ir_write", IR_write, 1);
      tick(); imem_ack = 1'b0; #1;
      chk("lw_imm_type", imm_type, 0);
      tick();
      chk("lw_src_sel", RS2_IMM_ALU_SRC_MUX_sel, 1);
      chk("lw_ex_read", D_MEM_read, 0);
      tick();
      chk("lw_mem1_read", D_MEM_read, 1);
      chk("lw_mem_mode", D_MEM_mode, 3'b010);
      tick();
      chk("lw_mem2_read", D_MEM_read, 1);
      tick();
      chk("lw_mem3_read", D_MEM_read, 1);
      tick(); dmem_ack = 1'b1; #1;
      chk_state("lw_mem4_state", MEM);
      chk("lw_mem4_read", D_MEM_read, 1);
      tick(); dmem_ack = 1'b0; #1;
      chk_state("lw_wb_state", WB);
      chk("lw_wb_dmem_sel", DMEM_ALU_WB_MUX_sel, 1);
      chk("lw_wb_rf_write", RF_write, 1);
      chk("lw_wb_read", D_MEM_read, 0);
      tick();
      chk_state("lw_done_fetch", FETCH);

      // SW with one dmem wait cycle
      imem_ack = 1'b1; instruction = 32'h0020A023; #1;
      tick(); imem_ack = 1'b0; #1;
      chk("sw_imm_type", imm_type, 1);
      tick();
      chk("sw_src_sel", RS2_IMM_ALU_SRC_MUX_sel, 1);
      tick();
      chk("sw_mem1_write", D_MEM_write, 1);
      chk("sw_mem1_rf_write", RF_write, 0);
      chk("sw_mem_mode", D_MEM_mode, 3'b010);
      tick(); dmem_ack = 1'b1; #1;
      chk("sw_mem2_write", D_MEM_write, 1);
      tick(); dmem_ack = 1'b0; #1;
      chk_state("sw_done_fetch", FETCH);
      chk("sw_after_write", D_MEM_write, 0);
      chk("sw_after_rf_write", RF_write, 0);

      // BEQ: FETCH, DECODE, EXECUTE, back to FETCH
      imem_ack = 1'b1; instruction = 32'h00208463; #1;
      tick(); imem_ack = 1'b0; #1;
      chk("beq_dec_imm", imm_type, 2);
      tick();
      chk_state("beq_ex_state", EXECUTE);
      chk("beq_branch", branch, 1);
      chk("beq_ex_imm", imm_type, 2);
      chk("beq_src_sel", RS2_IMM_ALU_SRC_MUX_sel, 0);
      tick();
      chk_state("beq_back_fetch", FETCH);
      chk("beq_branch_off", branch, 0);

      // JAL: jump and PC_write in EXECUTE, then WB
      imem_ack = 1'b1; instruction = 32'h0000006F; #1;
      tick(); imem_ack = 1'b0; #1;
      chk("jal_imm", imm_type, 4);
      tick();
      chk("jal_jump", jump, 1);
      chk("jal_pc_write", PC_write, 1);
      chk("jal_jalr", jalr, 0);
      tick();
      chk("jal_wb_rf_write", RF_write, 1);
      tick();

      // Fetch timeout: no ack for 4 cycles
      chk_state("to_w1_state", FETCH);
      chk("to_w1_req", imem_req, 1);
      tick(); tick(); tick();
      chk_state("to_w4_state", FETCH);
      chk("to_w4_halted", halted, 0);
      tick();
      chk_state("to_halt_state", HALT);
      chk("to_halted", halted, 1);
      chk("to_req_dropped", imem_req, 0);
      imem_ack = 1'b1; #1;
      chk("halt_ack_ir_write", IR_write, 0);
      tick();
      chk("halt_sticky", halted, 1);
      imem_ack = 1'b0;
      rst_n = 1'b0; #1;
      chk("halt_rst_clear", halted, 0);
      tick();
      rst_n = 1'b1; #1;
      chk_state("rst2_idle", IDLE);
      tick();

      // Ack on the 4th waiting cycle wins over the limit (SW fetched)
      chk_state("ack4_w1", FETCH);
      tick(); tick(); tick();
      imem_ack = 1'b1; instruction = 32'h0020A023; #1;
      chk("ack4_ir_write", IR_write, 1);
      tick(); imem_ack = 1'b0; #1;
      chk_state("ack4_decode", DECODE);
      chk("ack4_no_halt", halted, 0);
      tick(); tick();
      chk("mrst_write_before", D_MEM_write, 1);
      #2 rst_n = 1'b0; #1;
      chk("mrst_write_async", D_MEM_write, 0);
      chk_state("mrst_idle", IDLE);
      tick();
      rst_n = 1'b1; #1;
      chk_state("mrst_rel_idle", IDLE);
      tick();
      chk_state("mrst_rel_fetch", FETCH);

      // Unknown opcode 0x7F
      imem_ack = 1'b1; instruction = 32'h0000007F; #1;
      tick(); imem_ack = 1'b0; #1;
      chk_state("ill_decode", DECODE);
      tick();
`ifdef CU_ILLEGAL_TRAP_EN
      chk_state("ill_trap", TRAP);
      chk("ill_illegal_inst", illegal_inst, 1);
      chk("ill_trap_vec_sel", trap_vec_sel, 1);
      chk("ill_pc_write", PC_write, 1);
      tick();
      chk("ill_illegal_off", illegal_inst, 0);
`endif
      chk_state("ill_back_fetch", FETCH);
      chk("ill_no_halt", halted, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
